// File: rtl/spi_rx_deser.sv
// spi_rx_deser: receive-side deserializer for the ILI9341 SPI read path.
// Drops the leading dummy clocks, assembles MSB-first words from MISO and
// buffers them in a small FIFO that is drained over a valid/ready handshake.
module spi_rx_deser #(
    parameter int DW         = 8,
    parameter int DUMMY_BITS = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_sample_en,
    input  logic             i_miso,
    input  logic             i_cs,
    output logic [DW-1:0]    o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_abort,
    output logic             o_overflow
);
    localparam int BCW = (DW > 2) ? $clog2(DW) : 1;
    localparam int DCW = (DUMMY_BITS > 1) ? $clog2(DUMMY_BITS) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DUMMY, S_SHIFT, S_DONE} state_t;

    state_t           state_q;
    logic [DW-1:0]    sh_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic [DCW-1:0]   dcnt_q;
    logic [LEN_W-1:0] words_left_q;
    logic             cs_q;
    logic             done_q;
    logic             abort_q;
    logic             ovf_q;

    logic [DW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;

    logic             valid_smp;
    logic             capturing;
    logic             abort_now;
    logic             word_end;
    logic [DW-1:0]    push_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push_ok;
    logic             drop;

    // A strobe only counts while the panel is selected.
    assign valid_smp  = i_sample_en & ~i_cs;
    assign capturing  = (state_q == S_DUMMY) || (state_q == S_SHIFT);
    // Only a CS rising edge aborts, so a capture armed while CS is still high
    // simply waits for CS to drop.
    assign abort_now  = capturing & i_cs & ~cs_q;
    assign push_word  = {sh_q[DW-2:0], i_miso};
    assign word_end   = (state_q == S_SHIFT) & valid_smp & ~abort_now &
                        (bit_cnt_q == BCW'(DW - 1));
    assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign pop        = ~fifo_empty & i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok    = word_end & (~fifo_full | pop);
    assign drop       = word_end & fifo_full & ~pop;

    assign o_data     = fifo_empty ? '0 : mem[rd_ptr_q];
    assign o_valid    = ~fifo_empty;
    assign o_busy     = capturing;
    assign o_done     = done_q;
    assign o_abort    = abort_q;
    assign o_overflow = ovf_q;

    // Capture FSM: dummy skipping, bit assembly, word counting, status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            dcnt_q       <= '0;
            words_left_q <= '0;
            cs_q         <= 1'b1;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            cs_q    <= i_cs;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (drop) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            words_left_q <= i_len;
                            ovf_q        <= 1'b0;
                            bit_cnt_q    <= '0;
                            dcnt_q       <= '0;
                            sh_q         <= '0;
                            state_q      <= (DUMMY_BITS == 0) ? S_SHIFT : S_DUMMY;
                        end
                    end
                end
                S_DUMMY: begin
                    if (abort_now) begin
                        state_q <= S_IDLE;
                        abort_q <= 1'b1;
                    end else if (valid_smp) begin
                        if (dcnt_q == DCW'(DUMMY_BITS - 1)) begin
                            state_q <= S_SHIFT;
                        end else begin
                            dcnt_q <= dcnt_q + DCW'(1);
                        end
                    end
                end
                S_SHIFT: begin
                    if (abort_now) begin
                        state_q <= S_IDLE;
                        abort_q <= 1'b1;
                    end else if (valid_smp) begin
                        sh_q <= push_word;
                        if (bit_cnt_q == BCW'(DW - 1)) begin
                            bit_cnt_q    <= '0;
                            words_left_q <= words_left_q - LEN_W'(1);
                            if (words_left_q == LEN_W'(1)) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    // FIFO pointer registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates the output.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

endmodule
